ram_sp: RTL and testbench

- Single-port synchronous RAM: 2**N words of M bits, one shared address, registered read data.
- After every reset, a built-in sequencer clears all words to zero before normal access resumes.
- General-purpose storage primitive for datapath buffers and lookup tables.
- Single clock domain.

---
 rtl/ram_pkg.sv | 10 +
 rtl/ram_clear_seq.sv | 50 +++++
 rtl/ram_sp.sv | 86 ++++++++
 tb/tb_ram_sp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and FSM state type for the single-port RAM.
// Optional parity storage is enabled by defining RAM_PARITY_EN.
package ram_pkg;

    localparam int unsigned RAM_ADDR_W_DEF = 8;
    localparam int unsigned RAM_DATA_W_DEF = 8;

    typedef enum logic {CLEAR, READY} ram_state_t;

endpackage

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: sweeps every address once, writing zero, then
// hands the array over to normal access.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned N = RAM_ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    output logic         busy,
    output logic         clr_we,
    output logic [N-1:0] clr_addr
);

    ram_state_t   state, state_next;
    logic [N-1:0] ptr, ptr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        clr_we     = 1'b0;
        unique case (state)
            CLEAR: begin
                clr_we   = 1'b1;
                // Wrapping to zero coincides with the hand-over to READY.
                ptr_next = ptr + 1'b1;
                if (ptr == '1) begin
                    state_next = READY;
                end
            end
            READY: begin
                state_next = READY;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, 2**N x M, read-first, registered dout.
// Define RAM_PARITY_EN to store an even-parity bit per word and expose perr.
module ram_sp
    import ram_pkg::*;
#(
    parameter int unsigned N = RAM_ADDR_W_DEF,
    parameter int unsigned M = RAM_DATA_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [N-1:0] addr,
    input  logic [M-1:0] din,
    output logic [M-1:0] dout,
    output logic         busy
`ifdef RAM_PARITY_EN
    ,
    output logic         perr
`endif
);

    localparam int unsigned DEPTH = 2 ** N;

    logic [M-1:0] mem [DEPTH];

    logic         clr_we;
    logic [N-1:0] clr_addr;
    logic         we;
    logic [N-1:0] waddr;
    logic [M-1:0] wdata;

    ram_clear_seq #(
        .N(N)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // The sweep owns the write port; user writes during it are dropped.
    always_comb begin
        we    = clr_we | (wr & ~busy);
        waddr = addr;
        wdata = din;
        if (clr_we) begin
            waddr = clr_addr;
            wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // dout is never loaded during the sweep, so it keeps its reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (!busy) begin
            dout <= mem[addr];
        end
    end

`ifdef RAM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[waddr] <= ^wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr <= 1'b0;
        end else if (!busy) begin
            perr <= (^mem[addr]) != par_mem[addr];
        end
    end
`endif

endmodule

// File: tb/tb_ram_sp.sv
// Scoreboard bench for ram_sp: stimulus pushes expected read data per edge,
// a negedge monitor pops and compares against the DUT output.
module tb_ram_sp;

    localparam int N     = 8;
    localparam int M     = 8;
    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr = 1'b0;
    logic [N-1:0] addr = '0;
    logic [M-1:0] din = '0;
    logic [M-1:0] dout;
    logic         busy;
`ifdef RAM_PARITY_EN
    logic         perr;
`endif

    ram_sp #(
        .N(N),
        .M(M)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wr   (wr),
        .addr (addr),
        .din  (din),
        .dout (dout),
        .busy (busy)
`ifdef RAM_PARITY_EN
        ,
        .perr (perr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] d;
        logic       p;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] model [DEPTH];
    logic       bad   [DEPTH];
    exp_t       sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: the entry due on the edge just passed is compared here.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("dout", {24'd0, dout}, {24'd0, e.d});
`ifdef RAM_PARITY_EN
            chk("perr", {31'd0, perr}, {31'd0, e.p});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        wr    = w;
        addr  = a;
        din   = d;
        e.due = cyc + 1;
        e.d   = model[a];
        e.p   = bad[a];
        sbq.push_back(e);
        if (w) begin
            model[a] = d;
            bad[a]   = 1'b0;
        end
        step();
        wr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sbq.size() > 0; i++) step();
        if (sbq.size() != 0) begin
            chk("drain", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
`ifdef RAM_PARITY_EN
        chk("rst_perr", {31'd0, perr}, 32'd0);
`endif
        step();
        step();
        rst = 1'b0;
    endtask

    // Counts busy cycles after release; optionally attempts writes mid-sweep.
    task automatic wait_sweep(input bit poke);
        int n;
        bit dbad;
        n    = 0;
        dbad = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (dout !== 8'h00) dbad = 1'b1;
`ifdef RAM_PARITY_EN
            if (perr !== 1'b0) dbad = 1'b1;
`endif
            if (poke) begin
                if (n == 3) begin
                    wr   = 1'b1;
                    addr = 8'h05;
                    din  = 8'h77;
                end else if (n == 11) begin
                    addr = 8'h00;
                end else if (n == 12) begin
                    wr = 1'b0;
                end
            end
        end
        chk("busy_cycles", n, 256);
        chk("dout_during_clear", {31'd0, dbad}, 32'd0);
        @(posedge clk);
        #1;
        wr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 8'h00;
            bad[i]   = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] d;
        logic       w;

        #2;
        do_reset();
        wait_sweep(1'b1);

        access(1'b0, 8'd0, 8'h00);
        access(1'b0, 8'd17, 8'h00);
        access(1'b0, 8'd255, 8'h00);
        access(1'b0, 8'h05, 8'h00);
        access(1'b0, 8'h00, 8'h00);

        access(1'b1, 8'h10, 8'hA5);
        access(1'b0, 8'h10, 8'h00);
        access(1'b0, 8'h10, 8'h00);
        access(1'b1, 8'hFF, 8'h3C);
        access(1'b0, 8'hFF, 8'h00);
        access(1'b0, 8'hFF, 8'h00);

        access(1'b1, 8'h20, 8'h11);
        access(1'b1, 8'h20, 8'h22);
        access(1'b0, 8'h20, 8'h00);

        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            d = 8'($urandom);
            w = 1'($urandom_range(0, 1));
            access(w, a, d);
        end

`ifdef RAM_PARITY_EN
        access(1'b1, 8'h30, 8'h6B);
        access(1'b1, 8'h31, 8'h94);
        drain();
        // Deposit a single-bit upset into the stored word.
        dut.mem[48][0] = ~dut.mem[48][0];
        model[8'h30]   = model[8'h30] ^ 8'h01;
        bad[8'h30]     = 1'b1;
        access(1'b0, 8'h30, 8'h00);
        access(1'b0, 8'h31, 8'h00);
        access(1'b0, 8'h10, 8'h00);
`endif

        for (int i = 0; i < 16; i++) access(1'b1, 8'(i), 8'h5A);
        access(1'b0, 8'h0F, 8'h00);
        drain();
        do_reset();
        wait_sweep(1'b0);
        for (int i = 0; i < DEPTH; i++) access(1'b0, 8'(i), 8'h00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
